// File: rtl/flame_ctrl_if.sv
// Bundles the explosion request, maze RAM port and flame RAM write port of flame_ctrl.
interface flame_ctrl_if;
  logic       explode;
  logic [4:0] bomb_x;
  logic [4:0] bomb_y;
  logic [2:0] power;
  logic       frame_tick;
  logic       busy;
  logic       done;
  logic [9:0] maze_raddr;
  logic [1:0] maze_rdata;
  logic [9:0] maze_waddr;
  logic [1:0] maze_wdata;
  logic       maze_we;
  logic [9:0] flame_ram_waddr;
  logic [2:0] flame_ram_wdata;
  logic       flame_ram_we;

  modport master (
    input  explode, bomb_x, bomb_y, power, frame_tick, maze_rdata,
    output busy, done, maze_raddr, maze_waddr, maze_wdata, maze_we,
           flame_ram_waddr, flame_ram_wdata, flame_ram_we
  );

  modport slave (
    output explode, bomb_x, bomb_y, power, frame_tick, maze_rdata,
    input  busy, done, maze_raddr, maze_waddr, maze_wdata, maze_we,
           flame_ram_waddr, flame_ram_wdata, flame_ram_we
  );
endinterface

// File: rtl/flame_ctrl.sv
// Explosion sequencer: walks the blast in four directions against the maze,
// paints flame sprites, holds them for HOLD_FRAMES frames, then erases them.
module flame_ctrl #(
  parameter int MAZE_W      = 25,
  parameter int MAZE_H      = 17,
  parameter int HOLD_FRAMES = 30
) (
  input logic          clk,
  input logic          reset,
  flame_ctrl_if.master bus
);

  localparam int FW = $clog2(HOLD_FRAMES + 1) + 1;
  localparam logic [FW-1:0] HOLD_N = FW'(HOLD_FRAMES);
  localparam logic [5:0] W_LIM = 6'(MAZE_W);
  localparam logic [5:0] H_LIM = 6'(MAZE_H);

  typedef enum logic [2:0] {IDLE, CENTRE, READ, CHECK, HOLD, CLEAR, DONE} state_t;

  state_t          state, state_n;
  logic [4:0]      bx, by, bx_n, by_n;
  logic [2:0]      pwr, pwr_n;
  logic [2:0]      k, k_n;
  logic [1:0]      dir, dir_n;
  logic [3:0][2:0] len, len_n;
  logic [FW-1:0]   cnt, cnt_n;
  logic [5:0]      cx, cy;
  logic            in_bounds;
  logic [9:0]      cell_addr;
  logic [3:1]      has_len, later, cand;
  logic            adv;

  // Cursor = bomb + k*dir in 6-bit two's complement; k = 0 addresses the bomb cell itself.
  always_comb begin
    cx = {1'b0, bx};
    cy = {1'b0, by};
    case (dir)
      2'd0: cx = {1'b0, bx} + {3'b000, k};
      2'd1: cx = {1'b0, bx} - {3'b000, k};
      2'd2: cy = {1'b0, by} + {3'b000, k};
      default: cy = {1'b0, by} - {3'b000, k};
    endcase
    in_bounds = !cx[5] && (cx < W_LIM) && !cy[5] && (cy < H_LIM);
    cell_addr = {cy[4:0], cx[4:0]};
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      bx    <= '0;
      by    <= '0;
      pwr   <= '0;
      k     <= '0;
      dir   <= '0;
      len   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      bx    <= bx_n;
      by    <= by_n;
      pwr   <= pwr_n;
      k     <= k_n;
      dir   <= dir_n;
      len   <= len_n;
      cnt   <= cnt_n;
    end
  end

  // Next-state logic: blast walk, frame hold and the clear walk over recorded reaches.
  always_comb begin
    state_n = state;
    bx_n    = bx;
    by_n    = by;
    pwr_n   = pwr;
    k_n     = k;
    dir_n   = dir;
    len_n   = len;
    cnt_n   = cnt;
    adv     = 1'b0;
    has_len = {len[3] != 3'd0, len[2] != 3'd0, len[1] != 3'd0};
    case (dir)
      2'd0:    later = 3'b111;
      2'd1:    later = 3'b110;
      2'd2:    later = 3'b100;
      default: later = 3'b000;
    endcase
    cand = has_len & later;
    case (state)
      IDLE: begin
        if (bus.explode) begin
          bx_n    = bus.bomb_x;
          by_n    = bus.bomb_y;
          pwr_n   = (bus.power == 3'd0) ? 3'd1 : bus.power;
          dir_n   = 2'd0;
          k_n     = 3'd0;
          len_n   = '0;
          state_n = CENTRE;
        end
      end
      CENTRE: begin
        dir_n   = 2'd0;
        k_n     = 3'd1;
        state_n = READ;
      end
      READ: state_n = CHECK;
      CHECK: begin
        if (!in_bounds || bus.maze_rdata == 2'd1 || bus.maze_rdata == 2'd3) begin
          len_n[dir] = k - 3'd1;
          adv        = 1'b1;
        end else if (bus.maze_rdata == 2'd2 || k == pwr) begin
          len_n[dir] = k;
          adv        = 1'b1;
        end else begin
          k_n     = k + 3'd1;
          state_n = READ;
        end
        if (adv) begin
          if (dir == 2'd3) begin
            cnt_n   = '0;
            state_n = HOLD;
          end else begin
            dir_n   = dir + 2'd1;
            k_n     = 3'd1;
            state_n = READ;
          end
        end
      end
      HOLD: begin
        cnt_n = cnt + FW'(bus.frame_tick);
        if (cnt_n >= HOLD_N) begin
          dir_n   = 2'd0;
          k_n     = 3'd0;
          state_n = CLEAR;
        end
      end
      CLEAR: begin
        if (k < len[dir]) begin
          k_n = k + 3'd1;
        end else if (cand[1]) begin
          dir_n = 2'd1;
          k_n   = 3'd1;
        end else if (cand[2]) begin
          dir_n = 2'd2;
          k_n   = 3'd1;
        end else if (cand[3]) begin
          dir_n = 2'd3;
          k_n   = 3'd1;
        end else begin
          state_n = DONE;
        end
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Moore-style outputs plus the CHECK-cycle write strobes decoded from the maze data.
  always_comb begin
    bus.busy            = (state != IDLE) && (state != DONE);
    bus.done            = (state == DONE);
    bus.maze_raddr      = cell_addr;
    bus.maze_waddr      = cell_addr;
    bus.maze_wdata      = 2'b00;
    bus.maze_we         = 1'b0;
    bus.flame_ram_waddr = cell_addr;
    bus.flame_ram_wdata = 3'd0;
    bus.flame_ram_we    = 1'b0;
    case (state)
      CENTRE: begin
        bus.flame_ram_we    = 1'b1;
        bus.flame_ram_wdata = 3'd1;
      end
      CHECK: begin
        if (in_bounds && bus.maze_rdata == 2'd2) begin
          bus.flame_ram_we    = 1'b1;
          bus.flame_ram_wdata = 3'd4;
          bus.maze_we         = 1'b1;
        end else if (in_bounds && bus.maze_rdata == 2'd0) begin
          bus.flame_ram_we    = 1'b1;
          bus.flame_ram_wdata = dir[1] ? 3'd3 : 3'd2;
        end
      end
      CLEAR: begin
        bus.flame_ram_we    = 1'b1;
        bus.flame_ram_wdata = 3'd0;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_flame_ctrl.sv
// Directed testbench for flame_ctrl: scenario table with expected flame writes.
module tb_flame_ctrl;

  typedef struct {
    int bx;
    int by;
    int pw;
    int wall_a;
    int brick_a;
    int n_maze;
    int maze_a;
    int poke;
  } scen_t;

  typedef struct {
    int scen;
    int x;
    int y;
    int code;
  } exp_t;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  flame_ctrl_if bus ();

  flame_ctrl #(
    .MAZE_W(25),
    .MAZE_H(17),
    .HOLD_FRAMES(30)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  logic [1:0] maze [1024];
  logic [1:0] maze_q;

  // Maze RAM model with one cycle of read latency.
  always @(posedge clk) maze_q <= maze[bus.maze_raddr];

  assign bus.maze_rdata = maze_q;

  int la[$];
  int ld[$];
  int ma[$];
  int done_cnt = 0;

  // Log every strobe seen mid-cycle.
  always @(negedge clk) begin
    if (bus.flame_ram_we) begin
      la.push_back(int'(bus.flame_ram_waddr));
      ld.push_back(int'(bus.flame_ram_wdata));
    end
    if (bus.maze_we) ma.push_back(int'(bus.maze_waddr));
    if (bus.done) done_cnt++;
  end

  int compared   = 0;
  int mismatched = 0;
  scen_t scen [5];
  exp_t  expq [$];

  task automatic checkOutput(input string name, input int actual, input int expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic applyStimulus(input int bx, input int by, input int pw);
    step();
    bus.explode = 1'b1;
    bus.bomb_x  = 5'(bx);
    bus.bomb_y  = 5'(by);
    bus.power   = 3'(pw);
    step();
    bus.explode = 1'b0;
  endtask

  task automatic tick();
    step();
    bus.frame_tick = 1'b1;
    step();
    bus.frame_tick = 1'b0;
  endtask

  task automatic addExp(input int s, input int x, input int y, input int c);
    exp_t e;
    e.scen = s;
    e.x    = x;
    e.y    = y;
    e.code = c;
    expq.push_back(e);
  endtask

  task automatic clearMaze();
    for (int i = 0; i < 1024; i++) maze[i] = 2'd0;
  endtask

  task automatic checkWrites(input string name, input int s, input int base, input bit zero);
    int n = 0;
    int j = base;
    foreach (expq[i]) if (expq[i].scen == s) n++;
    checkOutput($sformatf("%s count", name), la.size() - base, n);
    foreach (expq[i]) begin
      if (expq[i].scen == s && j < la.size()) begin
        checkOutput($sformatf("%s addr #%0d", name, j - base), la[j], expq[i].y * 32 + expq[i].x);
        checkOutput($sformatf("%s code #%0d", name, j - base), ld[j], zero ? 0 : expq[i].code);
        j++;
      end
    end
  endtask

  task automatic runScenario(input int s);
    int base;
    int mbase;
    int dbase;
    int guard;
    clearMaze();
    if (scen[s].wall_a >= 0) maze[scen[s].wall_a] = 2'd1;
    if (scen[s].brick_a >= 0) maze[scen[s].brick_a] = 2'd2;
    base  = la.size();
    mbase = ma.size();
    dbase = done_cnt;
    applyStimulus(scen[s].bx, scen[s].by, scen[s].pw);
    checkOutput($sformatf("s%0d busy after explode", s), int'(bus.busy), 1);
    repeat (60) step();
    checkWrites($sformatf("s%0d set", s), s, base, 1'b0);
    checkOutput($sformatf("s%0d maze_we count", s), ma.size() - mbase, scen[s].n_maze);
    if (scen[s].n_maze > 0 && ma.size() > mbase)
      checkOutput($sformatf("s%0d maze_we addr", s), ma[mbase], scen[s].maze_a);
    base = la.size();
    for (int t = 0; t < 29; t++) begin
      tick();
      if (scen[s].poke != 0 && t == 9) applyStimulus(20, 10, 3);
    end
    repeat (3) step();
    checkOutput($sformatf("s%0d writes before last tick", s), la.size() - base, 0);
    checkOutput($sformatf("s%0d busy in hold", s), int'(bus.busy), 1);
    tick();
    guard = 0;
    while (bus.busy && guard < 40) begin
      step();
      guard++;
    end
    checkOutput($sformatf("s%0d finished in time", s), int'(guard < 40), 1);
    repeat (5) step();
    checkWrites($sformatf("s%0d clear", s), s, base, 1'b1);
    checkOutput($sformatf("s%0d done pulses", s), done_cnt - dbase, 1);
    checkOutput($sformatf("s%0d busy at end", s), int'(bus.busy), 0);
  endtask

  initial begin
    int base;
    int guard;
    int n_after;

    scen[0] = '{bx: 5,  by: 5,  pw: 2, wall_a: -1, brick_a: -1, n_maze: 0, maze_a: 0,  poke: 0};
    scen[1] = '{bx: 1,  by: 1,  pw: 3, wall_a: 34, brick_a: 97, n_maze: 1, maze_a: 97, poke: 0};
    scen[2] = '{bx: 24, by: 16, pw: 7, wall_a: -1, brick_a: -1, n_maze: 0, maze_a: 0,  poke: 0};
    scen[3] = '{bx: 10, by: 8,  pw: 0, wall_a: -1, brick_a: -1, n_maze: 0, maze_a: 0,  poke: 0};
    scen[4] = '{bx: 5,  by: 5,  pw: 1, wall_a: -1, brick_a: -1, n_maze: 0, maze_a: 0,  poke: 1};

    addExp(0, 5, 5, 1); addExp(0, 6, 5, 2); addExp(0, 7, 5, 2);
    addExp(0, 4, 5, 2); addExp(0, 3, 5, 2); addExp(0, 5, 6, 3);
    addExp(0, 5, 7, 3); addExp(0, 5, 4, 3); addExp(0, 5, 3, 3);

    addExp(1, 1, 1, 1); addExp(1, 0, 1, 2); addExp(1, 1, 2, 3);
    addExp(1, 1, 3, 4); addExp(1, 1, 0, 3);

    addExp(2, 24, 16, 1);
    for (int x = 23; x >= 17; x--) addExp(2, x, 16, 2);
    for (int y = 15; y >= 9; y--) addExp(2, 24, y, 3);

    addExp(3, 10, 8, 1); addExp(3, 11, 8, 2); addExp(3, 9, 8, 2);
    addExp(3, 10, 9, 3); addExp(3, 10, 7, 3);

    addExp(4, 5, 5, 1); addExp(4, 6, 5, 2); addExp(4, 4, 5, 2);
    addExp(4, 5, 6, 3); addExp(4, 5, 4, 3);

    clearMaze();
    reset          = 1'b1;
    bus.explode    = 1'b0;
    bus.bomb_x     = '0;
    bus.bomb_y     = '0;
    bus.power      = '0;
    bus.frame_tick = 1'b0;
    repeat (3) step();
    checkOutput("reset busy", int'(bus.busy), 0);
    checkOutput("reset done", int'(bus.done), 0);
    checkOutput("reset flame_ram_we", int'(bus.flame_ram_we), 0);
    checkOutput("reset maze_we", int'(bus.maze_we), 0);
    reset = 1'b0;
    step();

    for (int s = 0; s < 5; s++) runScenario(s);

    clearMaze();
    base = la.size();
    applyStimulus(12, 8, 3);
    guard = 0;
    while (la.size() - base < 8 && guard < 100) begin
      step();
      guard++;
    end
    checkOutput("rst reached down walk", int'(guard < 100), 1);
    if (la.size() - base >= 8) begin
      checkOutput("rst first down addr", la[base + 7], 9 * 32 + 12);
      checkOutput("rst first down code", ld[base + 7], 3);
    end
    reset = 1'b1;
    step();
    checkOutput("rst busy", int'(bus.busy), 0);
    checkOutput("rst flame_ram_we", int'(bus.flame_ram_we), 0);
    checkOutput("rst maze_we", int'(bus.maze_we), 0);
    n_after = la.size();
    reset = 1'b0;
    repeat (4) step();
    checkOutput("rst no writes after", la.size() - n_after, 0);
    checkOutput("rst still idle", int'(bus.busy), 0);

    runScenario(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/flame_ctrl.md
Name: flame_ctrl

Overview:
- Explosion sequencer directly upstream of the flame renderer.
- On a bomb explosion it walks the blast outward in 4 directions against the maze RAM, destroying the first brick hit in each direction, and writes flame sprite codes into the renderer's 32x32 flame RAM.
- It holds the flames for a number of video frames, then erases exactly the cells it wrote.
- Drives the renderer's write port (flame_ram_waddr/wdata/we); cell address = {y[4:0], x[4:0]}.

Parameters:
- MAZE_W, 25, maze width in cells; valid x = 0..MAZE_W-1.
- MAZE_H, 17, maze height in cells; valid y = 0..MAZE_H-1.
- HOLD_FRAMES, 30, number of frame_tick pulses that flames stay displayed.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- explode  in  1  1-cycle request; sampled only in IDLE
- bomb_x  in  5  bomb cell x, sampled with explode
- bomb_y  in  5  bomb cell y, sampled with explode
- power  in  3  blast reach in cells; 0 is treated as 1
- frame_tick  in  1  1-cycle pulse per video frame
- busy  out  1  high from the cycle after an accepted explode until done
- done  out  1  1-cycle pulse after the clear phase completes
- maze_raddr  out  10  maze read address {y,x}; 1-cycle read latency
- maze_rdata  in  2  cell type: 0 empty, 1 hard wall, 2 brick, 3 treated as wall
- maze_waddr  out  10  maze write address
- maze_wdata  out  2  always 0
- maze_we  out  1  clears a brick
- flame_ram_waddr  out  10  flame RAM write address
- flame_ram_wdata  out  3  sprite code: 0 empty, 1 centre, 2 horizontal, 3 vertical, 4 burning brick
- flame_ram_we  out  1  flame RAM write strobe

Behaviour:
- Reset:
  - state = IDLE; busy, done, maze_we, flame_ram_we = 0; reach registers = 0.
  - Flame RAM contents are not touched. Reset mid-operation abandons the sequence, leaving already-written cells in place.
- Direction order: RIGHT(+x), LEFT(-x), DOWN(+y), UP(-y). Per-direction reach registers len[d] are 3 bits each.
- IDLE:
  - On explode, latch bomb_x, bomb_y and max(power,1) → CENTRE.
  - explode is ignored in every other state.
- CENTRE (1 cycle):
  - Write code 1 at the bomb cell.
  - Set d = RIGHT, k = 1 → READ.
- READ (1 cycle):
  - Cursor = bomb + k·dir, computed as 6-bit signed.
  - maze_raddr = cursor (combinational from cursor).
- CHECK (1 cycle): uses maze_rdata returned for the cursor. Cases:
  - Cursor out of bounds (x<0, x≥MAZE_W, y<0, y≥MAZE_H), or rdata = 1/3: no write; len[d] = k-1; next direction.
  - rdata = 2: write code 4 at cursor; maze_we = 1 at the same address; len[d] = k; next direction.
  - rdata = 0: write code 2 (RIGHT/LEFT) or 3 (DOWN/UP). Then:
    - if k = power: len[d] = k; next direction;
    - else k++ → READ.
- Next direction: k = 1 → READ; after UP → HOLD.
- Timing per cell: 2 cycles (READ + CHECK), including the stopping cell. All writes are single-cycle strobes during CHECK or CENTRE.
- HOLD:
  - Frame counter starts at 0 and increments on each frame_tick.
  - When the count reaches HOLD_FRAMES → CLEAR (HOLD_FRAMES = 0 passes through immediately).
  - A frame_tick coinciding with state entry counts.
- CLEAR:
  - Write code 0 to the centre, then to cells 1..len[d] for each direction in the same order.
  - 1 cycle per cell; no maze reads. Brick cells that have since been cleared are still erased.
- DONE: done = 1 for 1 cycle; busy drops in the same cycle → IDLE.
- Overlap rule: overlapping flames from other bombs are overwritten; CLEAR writes 0 unconditionally. Arbitration is external.

Test Plan:
- Open field: bomb (5,5), power 2, all maze 0 → 9 flame writes in order: (5,5)=1, (6,5)=2, (7,5)=2, (4,5)=2, (3,5)=2, (5,6)=3, (5,7)=3, (5,4)=3, (5,3)=3; no maze_we. After 30 ticks, 9 zero-writes to the same cells; done pulse; busy low.
- Walls: bomb (1,1), power 3, wall at (2,1), brick at (1,3) → RIGHT: no writes. LEFT: (0,1)=2, stops at x=-1. DOWN: (1,2)=3, (1,3)=4, maze_we at addr {3,1}. UP: (1,0)=3. len = {0,1,2,1}; clear erases exactly 5 cells.
- Edge/wrap: bomb (24,16), power 7 → RIGHT and DOWN write nothing (no wrap to x=25..31/y=17..31); LEFT writes x=23..17; UP writes y=15..9.
- Power 0 → behaves as power 1: 5 writes total.
- explode pulsed during HOLD → ignored; the bomb latched at acceptance is unchanged; exactly one done.
- reset asserted in the middle of the DOWN walk → next cycle busy=0, no strobes; a new explode after reset runs a complete sequence normally.
